// File: rtl/note_sequencer.sv
// Square-wave note playback engine: fetches 32-bit note words from a memory read
// port, plays each tone for its encoded duration, and stops on END, stop or range overflow.
module note_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] TICK_DIV  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] mem_addr,
  input  logic [31:0] note,
  input  logic        too_high,
  output logic        audio_out,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [11:0] note_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_NEXT,
    S_DONE
  } state_t;

  // Low address bits are forced to zero so every fetch is word-aligned.
  localparam logic [31:0] BASE_WORD = {BASE_ADDR[31:2], 2'b00};
  localparam logic [15:0] TICK_LAST = TICK_DIV - 16'd1;

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic        audio_q, audio_d;
  logic        error_q, error_d;
  logic [15:0] tick_q,  tick_d;
  logic [14:0] dur_q,   dur_d;
  logic [15:0] half_q,  half_d;
  logic [15:0] hcnt_q,  hcnt_d;

  logic [14:0] note_dur;
  logic [15:0] note_half;

  assign note_dur  = note[30:16];
  assign note_half = note[15:0];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    audio_d = audio_q;
    error_d = error_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    half_d  = half_q;
    hcnt_d  = hcnt_q;

    unique case (state_q)
      S_IDLE: begin
        audio_d = 1'b0;
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (too_high) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else if (note[31]) begin
          state_d = S_DONE;
          error_d = 1'b0;
        end else if (note_dur == 15'd0) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_PLAY;
          dur_d   = note_dur;
          half_d  = note_half;
          tick_d  = 16'd0;
          hcnt_d  = 16'd0;
          audio_d = 1'b0;
        end
      end

      S_PLAY: begin
        if (half_q != 16'd0) begin
          if (hcnt_q == half_q - 16'd1) begin
            hcnt_d  = 16'd0;
            audio_d = ~audio_q;
          end else begin
            hcnt_d  = hcnt_q + 16'd1;
          end
        end else begin
          audio_d = 1'b0;
        end

        if (tick_q == TICK_LAST) begin
          tick_d = 16'd0;
          dur_d  = dur_q - 15'd1;
          // The final tick of the final duration unit ends the note.
          if (dur_q == 15'd1) begin
            state_d = S_NEXT;
            audio_d = 1'b0;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end

      S_NEXT: begin
        audio_d = 1'b0;
        addr_d  = addr_q + 32'd4;
        state_d = S_FETCH;
      end

      S_DONE: begin
        audio_d = 1'b0;
        if (start) begin
          error_d = 1'b0;
          addr_d  = BASE_WORD;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition above, including a simultaneous start.
    if (stop) begin
      state_d = S_IDLE;
      addr_d  = BASE_WORD;
      audio_d = 1'b0;
      error_d = 1'b0;
      tick_d  = 16'd0;
      dur_d   = 15'd0;
      hcnt_d  = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_WORD;
      audio_q <= 1'b0;
      error_q <= 1'b0;
      tick_q  <= 16'd0;
      dur_q   <= 15'd0;
      half_q  <= 16'd0;
      hcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      audio_q <= audio_d;
      error_q <= error_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      half_q  <= half_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign mem_addr  = addr_q;
  assign note_idx  = addr_q[13:2];
  assign audio_out = audio_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_PLAY) || (state_q == S_NEXT);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_DONE) && error_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: a behavioural note memory plus a
// per-cycle scoreboard of expected outputs built from note timing rules.
module tb_note_sequencer;

  localparam logic [15:0] TD = 16'd4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [31:0] mem_addr;
  logic [31:0] note;
  logic        too_high;
  logic        audio_out;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] note_idx;

  logic [31:0] mem [0:4095];

  assign note     = mem[mem_addr[13:2]];
  assign too_high = |mem_addr[31:14];

  note_sequencer #(
    .BASE_ADDR(32'h0000_0000),
    .TICK_DIV (TD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mem_addr (mem_addr),
    .note     (note),
    .too_high (too_high),
    .audio_out(audio_out),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .note_idx (note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        audio;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  typedef struct {
    logic [14:0] dur;
    logic [15:0] half;
    int          exp_cycles;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cycles;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] addr, input logic audio,
                              input logic b, input logic d, input logic e);
    exp_t x;
    x.addr = addr; x.audio = audio; x.busy = b; x.done = d; x.err = e;
    return x;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_fetch(input logic [31:0] addr);
    sb_q.push_back(mk(addr, 1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic push_done(input logic [31:0] addr, input logic e, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(mk(addr, 1'b0, 1'b0, 1'b1, e));
  endtask

  // One note: FETCH, then DUR*TD play cycles (audio flips every HALF cycles), then NEXT.
  task automatic push_note(input logic [31:0] addr, input logic [14:0] dur, input logic [15:0] half);
    int h;
    logic a;
    h = int'(half);
    push_fetch(addr);
    for (int k = 0; k < int'(dur) * int'(TD); k++) begin
      a = (h == 0) ? 1'b0 : logic'((k / h) % 2);
      sb_q.push_back(mk(addr, a, 1'b1, 1'b0, 1'b0));
    end
    sb_q.push_back(mk(addr, 1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string name);
    exp_t x;
    exp_t act;
    x   = sb_q.pop_front();
    act = {mem_addr, audio_out, busy, done, error};
    check(name, 64'(act), 64'(x));
    if (busy) busy_cycles++;
    step();
  endtask

  task automatic drain(input string name, input int keep);
    while (sb_q.size() > keep) step_check(name);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    vec_t tbl [5];
    int   sum_cycles;

    tbl = '{
      '{15'd3, 16'd2, 14},
      '{15'd0, 16'd7,  2},
      '{15'd2, 16'd0, 10},
      '{15'd1, 16'd3,  6},
      '{15'd2, 16'd5, 10}
    };

    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    #1;
    step();
    step();

    check("reset_outputs", 64'({mem_addr, audio_out, busy, done, error}), 64'h0);
    check("reset_note_idx", 64'(note_idx), 64'h0);
    rst_n = 1'b1;
    push_idle(16);
    drain("idle_hold", 0);

    // Table-driven program: tone, skipped note, rest, short tones, then END.
    sum_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      mem[i] = {1'b0, tbl[i].dur, tbl[i].half};
      sum_cycles += tbl[i].exp_cycles;
      push_note(32'(4 * i), tbl[i].dur, tbl[i].half);
    end
    mem[5] = 32'h8000_0000;
    push_fetch(32'd20);
    push_done(32'd20, 1'b0, 3);
    pulse_start();
    busy_cycles = 0;
    drain("program", 0);
    check("program_busy_cycles", 64'(busy_cycles), 64'(sum_cycles + 1));

    // Abort mid-PLAY with an ignored start pulse; restart from DONE reloads BASE.
    mem[0] = {1'b0, 15'd3, 16'd3};
    pulse_start();
    push_fetch(32'h0);
    for (int k = 0; k < 5; k++) sb_q.push_back(mk(32'h0, logic'((k / 3) % 2), 1'b1, 1'b0, 1'b0));
    step_check("abort_fetch");
    step_check("abort_play");
    start = 1'b1;
    step_check("abort_play_start_ignored");
    start = 1'b0;
    step_check("abort_play");
    step_check("abort_play");
    stop = 1'b1;
    step_check("abort_play_last");
    stop = 1'b0;
    push_idle(3);
    drain("abort_idle", 0);

    // Reset during PLAY silences audio at that same edge.
    mem[0] = {1'b0, 15'd3, 16'd2};
    pulse_start();
    push_fetch(32'h0);
    for (int k = 0; k < 4; k++) sb_q.push_back(mk(32'h0, logic'((k / 2) % 2), 1'b1, 1'b0, 1'b0));
    drain("rst_play", 1);
    rst_n = 1'b0;
    step_check("rst_play_last");
    rst_n = 1'b1;
    push_idle(2);
    drain("rst_idle", 0);

    // Walk every word of the 16 KiB range until too_high ends playback.
    for (int i = 0; i < 4096; i++) mem[i] = {1'b0, 15'd1, 16'd1};
    for (int i = 0; i < 4096; i++) push_note(32'(4 * i), 15'd1, 16'd1);
    push_fetch(32'h0000_4000);
    push_done(32'h0000_4000, 1'b1, 4);
    pulse_start();
    drain("range", 6);
    check("range_idx_last", 64'(note_idx), 64'hFFF);
    step_check("range_next");
    check("range_idx_wrap", 64'(note_idx), 64'h0);
    drain("range_end", 0);

    // Restart after an error: error clears and FETCH runs at BASE_ADDR.
    mem[0] = 32'h8000_0000;
    pulse_start();
    push_fetch(32'h0);
    push_done(32'h0, 1'b0, 2);
    drain("restart", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Note playback engine that reads the note memory's instruction port and produces a square-wave audio bit. On `start` it walks word-aligned addresses from `BASE_ADDR`. It fetches each 32-bit note word, plays that tone for the encoded duration, then advances to the next word. It stops on an end marker, on a `stop` request, or when the address leaves the implemented 16 KiB range, which the memory reports on `too_high`.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first note; must be word-aligned.
- `TICK_DIV`, default 16'd50000: clk cycles per duration tick; legal range 1..65535.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `rst_n` input 1: one clock; reset is synchronous and active-low.
- `start` input 1: one-cycle request to begin playback; honoured only in IDLE or DONE.
- `stop` input 1: abort; returns to IDLE on the next edge from any state.
- `mem_addr` output 32: note address driven to the memory read port.
- `note` input 32: note word, combinational function of `mem_addr`.
- `too_high` input 1: memory flag, high when `mem_addr[31:14]` is nonzero.
- `audio_out` output 1: square-wave tone output.
- `busy` output 1: high in FETCH, PLAY and NEXT.
- `done` output 1: high in DONE.
- `error` output 1: high in DONE when playback ended on `too_high`.
- `note_idx` output 12: index of the current note, `mem_addr[13:2]`.

## Operation
- **Note word format:**
  - `note[31]` is END.
  - `note[30:16]` is DUR, the duration in ticks (15 bits).
  - `note[15:0]` is HALF, the half-period in clk cycles; HALF=0 is a rest.
- **State machine:** states are IDLE, FETCH, PLAY, NEXT, DONE.
- **IDLE:**
  - `mem_addr`=`BASE_ADDR`, `audio_out`=0, `busy`=0, `done`=0.
  - `start` moves to FETCH.
- **FETCH (exactly one cycle):** `note` is sampled this cycle. Priority order:
  1. `too_high`: go to DONE with `error`=1.
  2. END: go to DONE with `error`=0.
  3. DUR=0: go to NEXT, with nothing played.
  4. Otherwise latch DUR and HALF, clear the tick, duration and half-period counters, set `audio_out`=0, and go to PLAY.
- **PLAY:**
  - Tick counter runs 0..`TICK_DIV`-1; at wrap the remaining-duration counter decrements.
  - Leave for NEXT on the cycle the last tick completes; PLAY lasts exactly DUR×`TICK_DIV` cycles.
  - If HALF≠0: the half-period counter runs 0..HALF-1 and toggles `audio_out` at wrap.
  - If HALF=0: `audio_out` is held 0.
- **NEXT (one cycle):**
  - `audio_out`←0 and `mem_addr`←`mem_addr`+4, in 32-bit arithmetic with no saturation; the range check is left to `too_high`.
  - Go to FETCH.
- **DONE:**
  - `done`=1, `audio_out`=0, `mem_addr` holds its last value, `error` holds its latched value.
  - `start` clears `error`, reloads `BASE_ADDR` and goes to FETCH.
- **Control conflicts:**
  - `stop` has priority over `start` and over all transitions.
  - `start` while `busy` is ignored.
- **Address alignment:** `mem_addr[1:0]` is always 0.

## Timing
- **Reset:** synchronous on `rst_n`=0.
  - State is IDLE; `mem_addr`=`BASE_ADDR`.
  - `audio_out`, `busy`, `done` and `error` are 0; all counters are 0.
  - Reset mid-PLAY silences `audio_out` at that same edge.
- **Start latency:** `start` sampled at edge N gives FETCH during cycle N+1, with `mem_addr`=`BASE_ADDR` and `busy`=1.
- **Per-note latency:** FETCH 1 + PLAY DUR×`TICK_DIV` + NEXT 1 cycles; a skipped note (DUR=0) costs 2 cycles.
- **Tone period:** the first `audio_out` toggle comes HALF cycles after PLAY entry, then every HALF cycles.
- **Counter widths:**
  - Tick and half-period counters are 16 bits; duration counter is 15 bits.
  - No counter overflows for legal parameters.
- **Address wrap:** if `mem_addr` reaches 32'h0000_4000, `too_high` asserts and the sequencer ends in DONE with `error`=1.
- **Stop timing:** `stop` in PLAY forces `audio_out`=0, `busy`=0 and IDLE at the next edge.

## Test plan
- **Reset:** reset with `TICK_DIV`=4 → all outputs 0 and `mem_addr`=0; after release, idle indefinitely with no `start` → outputs unchanged.
- **Single tone:** mem[0]={0,DUR=3,HALF=2}, mem[1]=32'h8000_0000, then pulse `start` →
  - PLAY lasts 12 cycles, with `audio_out` toggling every 2 cycles (6 toggles).
  - NEXT, then FETCH at address 4, then DONE with `error`=0.
- **Rest and zero duration:** mem[0]={DUR=0}, mem[1]={DUR=2,HALF=0}, mem[2]=END →
  - mem[0] is skipped in 2 cycles.
  - mem[1] plays 8 cycles with `audio_out`=0.
  - Ends in DONE.
- **Out of range:** fill all 4096 words with {DUR=1,HALF=1} →
  - `note_idx` wraps from 4095; FETCH at 32'h4000 sees `too_high`.
  - DONE with `error`=1; `mem_addr` holds 32'h4000.
- **Abort and ignored start:** `stop` at the 5th cycle of PLAY → IDLE next edge with `audio_out`=0. A `start` pulse during PLAY has no effect.
- **Restart:** after a DONE with `error`=1, pulse `start` → `error` clears and FETCH runs at `BASE_ADDR`.
